// File: rtl/true_dual_port_ram.sv
// Single-clock true dual-port RAM: synchronous writes, combinational reads on both ports.
// Optional `COLLISION_FLAG_EN adds a registered same-address write collision flag.
module true_dual_port_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [WIDTH-1:0]  data_a,
   output logic [WIDTH-1:0]  q_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [WIDTH-1:0]  data_b,
   output logic [WIDTH-1:0]  q_b
`ifdef COLLISION_FLAG_EN
   ,
   output logic              collision
`endif
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             a_ok_s;
   logic             b_ok_s;

   // Address range qualification; only non-power-of-two depths can fail it.
   always_comb begin
      a_ok_s = 1'b0;
      b_ok_s = 1'b0;
      if ({1'b0, addr_a} < DEPTH_W) begin
         a_ok_s = 1'b1;
      end else begin
         a_ok_s = 1'b0;
      end
      if ({1'b0, addr_b} < DEPTH_W) begin
         b_ok_s = 1'b1;
      end else begin
         b_ok_s = 1'b0;
      end
   end

   // Storage update; port B is written last so it wins a same-address write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_r <= '{default: '0};
      end else begin
         if (we_a && a_ok_s) begin
            mem_r[addr_a] <= data_a;
         end
         if (we_b && b_ok_s) begin
            mem_r[addr_b] <= data_b;
         end
      end
   end

   // Asynchronous read ports; out-of-range addresses read as zero.
   always_comb begin
      q_a = '0;
      q_b = '0;
      if (a_ok_s) begin
         q_a = mem_r[addr_a];
      end else begin
         q_a = '0;
      end
      if (b_ok_s) begin
         q_b = mem_r[addr_b];
      end else begin
         q_b = '0;
      end
   end

`ifdef COLLISION_FLAG_EN
   logic collision_r;

   // One-cycle pulse after any edge where both ports wrote the same address.
   always_ff @(posedge clk) begin
      if (rst) begin
         collision_r <= 1'b0;
      end else begin
         collision_r <= we_a && we_b && (addr_a == addr_b);
      end
   end

   assign collision = collision_r;
`endif

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Self-checking bench for true_dual_port_ram: directed scenarios plus random traffic
// compared against a plain array model of the memory.
module tb_true_dual_port_ram;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk;
   logic              rst;
   logic              we_a;
   logic [ADDR_W-1:0] addr_a;
   logic [WIDTH-1:0]  data_a;
   logic [WIDTH-1:0]  q_a;
   logic              we_b;
   logic [ADDR_W-1:0] addr_b;
   logic [WIDTH-1:0]  data_b;
   logic [WIDTH-1:0]  q_b;
`ifdef COLLISION_FLAG_EN
   logic              collision;
`endif

   logic [WIDTH-1:0] model [DEPTH];
   logic             exp_coll;
   int               errors;
   int               checks;

   true_dual_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .we_a   (we_a),
      .addr_a (addr_a),
      .data_a (data_a),
      .q_a    (q_a),
      .we_b   (we_b),
      .addr_b (addr_b),
      .data_b (data_b),
      .q_b    (q_b)
`ifdef COLLISION_FLAG_EN
      ,
      .collision (collision)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_coll(input string tag);
`ifdef COLLISION_FLAG_EN
      chk(tag, {7'd0, collision}, {7'd0, exp_coll});
`endif
   endtask

   // One clock of traffic: checks old data before the edge, new data after it.
   task automatic step(input logic r,
                       input logic wa, input logic [ADDR_W-1:0] aa, input logic [WIDTH-1:0] da,
                       input logic wb, input logic [ADDR_W-1:0] ab, input logic [WIDTH-1:0] db);
      rst = r; we_a = wa; addr_a = aa; data_a = da;
      we_b = wb; addr_b = ab; data_b = db;
      #1;
      chk("pre_q_a", q_a, model[aa]);
      chk("pre_q_b", q_b, model[ab]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
      end else begin
         if (wa) model[aa] = da;
         if (wb) model[ab] = db;
      end
      exp_coll = !r && wa && wb && (aa == ab);
      #1;
      chk("post_q_a", q_a, model[aa]);
      chk("post_q_b", q_b, model[ab]);
      chk_coll("collision");
      rst = 1'b0; we_a = 1'b0; we_b = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0]  d;
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] a2;
      errors = 0;
      checks = 0;
      exp_coll = 1'b0;
      rst = 1'b1; we_a = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

      // 1. Reset, then sweep both ports.
      @(posedge clk);
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
      #1;
      rst = 1'b0;
      chk_coll("collision_reset");
      for (int i = 0; i < DEPTH; i++) begin
         addr_a = ADDR_W'(i);
         addr_b = ADDR_W'(DEPTH - 1 - i);
         #1;
         chk("reset_q_a", q_a, 8'h00);
         chk("reset_q_b", q_b, 8'h00);
      end

      // 2. Port A writes every address, port B watches the same address.
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom);
         step(1'b0, 1'b1, ADDR_W'(i), d, 1'b0, ADDR_W'(i), 8'h00);
         chk("a_wr_q_b", q_b, d);
      end

      // 3. Port B overwrites, including addr 5 <- 3C.
      step(1'b0, 1'b0, 6'd5, 8'h00, 1'b1, 6'd5, 8'h3C);
      chk("b_wr_q_a5", q_a, 8'h3C);
      chk("b_wr_q_b5", q_b, 8'h3C);
      for (int i = 0; i < DEPTH; i += 3) begin
         step(1'b0, 1'b0, ADDR_W'(i), 8'h00, 1'b1, ADDR_W'(i), 8'($urandom));
      end

      // 4. Simultaneous writes to different addresses.
      step(1'b0, 1'b1, 6'd18, 8'h95, 1'b1, 6'd7, 8'h4B);
      chk("dual_q_a18", q_a, 8'h95);
      chk("dual_q_b7", q_b, 8'h4B);

      // 5. Same-address collision: port B wins.
      step(1'b0, 1'b1, 6'd42, 8'hAA, 1'b1, 6'd42, 8'h55);
      chk("coll_q_a", q_a, 8'h55);
      chk("coll_q_b", q_b, 8'h55);
      step(1'b0, 1'b0, 6'd42, 8'h00, 1'b0, 6'd42, 8'h00);
      chk("coll_hold", q_a, 8'h55);

      // 6. Reset overrides a concurrent write, then writes resume.
      step(1'b0, 1'b1, 6'd10, 8'hF0, 1'b0, 6'd10, 8'h00);
      chk("fill_10", q_a, 8'hF0);
      step(1'b1, 1'b1, 6'd10, 8'h11, 1'b1, 6'd10, 8'h22);
      chk("rst_q_a10", q_a, 8'h00);
      step(1'b0, 1'b0, 6'd18, 8'h00, 1'b0, 6'd42, 8'h00);
      chk("rst_q_a18", q_a, 8'h00);
      chk("rst_q_b42", q_b, 8'h00);
      step(1'b0, 1'b1, 6'd10, 8'h11, 1'b0, 6'd10, 8'h00);
      chk("after_rst_wr", q_b, 8'h11);

      // Random traffic, biased toward address collisions.
      for (int n = 0; n < 300; n++) begin
         a1 = ADDR_W'($urandom_range(DEPTH - 1, 0));
         a2 = ($urandom_range(3, 0) == 0) ? a1 : ADDR_W'($urandom_range(DEPTH - 1, 0));
         step(($urandom_range(40, 0) == 0),
              1'($urandom), a1, 8'($urandom),
              1'($urandom), a2, 8'($urandom));
      end

      // Final sweep of the whole array against the model.
      for (int i = 0; i < DEPTH; i++) begin
         addr_a = ADDR_W'(i);
         addr_b = ADDR_W'(DEPTH - 1 - i);
         #1;
         chk("final_q_a", q_a, model[i]);
         chk("final_q_b", q_b, model[DEPTH - 1 - i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/true_dual_port_ram.md
Name: true_dual_port_ram

Overview:
Single-clock true dual-port RAM with two fully independent ports, A and B. Each port can write synchronously and read combinationally at any address. It serves as a general-purpose shared scratch memory between two requesters in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 64, number of words (>=2; need not be a power of two)
ADDR_W, $clog2(DEPTH), derived localparam, address width; not overridable

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we_a  input  1  port A write enable
addr_a  input  ADDR_W  port A address (read and write)
data_a  input  WIDTH  port A write data
q_a  output  WIDTH  port A read data
we_b  input  1  port B write enable
addr_b  input  ADDR_W  port B address (read and write)
data_b  input  WIDTH  port B write data
q_b  output  WIDTH  port B read data

Behaviour:
- Storage: DEPTH x WIDTH array, mem[0..DEPTH-1].
- Reset: one clock with rst=1 clears every word to 0 at that rising edge. q_a and q_b read 0 afterwards. rst has priority over we_a/we_b in the same cycle.
- Write, port A: at rising clk with rst=0 and we_a=1, mem[addr_a] <= data_a. Port B writes identically with we_b, addr_b and data_b.
- Read: asynchronous, zero-cycle latency. q_a = mem[addr_a] and q_b = mem[addr_b] combinationally; reads ignore the we_* inputs.
- Read after write: a written value is visible on q of both ports immediately after the writing edge, before the next edge, for any port addressing that location.
- During a write cycle, q reflects the old contents until the edge, then the new value (write-first as seen after the edge).
- Simultaneous writes to different addresses: both complete in the same cycle.
- Simultaneous writes to the same address: port B's data is stored and port A's write is discarded.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two): the write is ignored and the read returns 0.
- No X propagation: q is 0 for any uninitialised word after reset. Before the first reset, contents are undefined.

Optional Feature:
COLLISION_FLAG_EN
- Defined: adds output port collision (1 bit), placed after q_b.
  - Registered; reset value 0.
  - Set to 1 for exactly one cycle after any rising edge where rst=0, we_a=1, we_b=1 and addr_a==addr_b. Otherwise 0.
  - Port-B-wins storage rule is unchanged.
- Not defined: no collision port and no collision logic. Memory behaviour is identical.

Test Plan:
1. Reset then read: rst=1 for 1 cycle, then sweep addr_a/addr_b over 0..63 -> q_a=q_b=8'h00 at every address.
2. Port A write/read: for addr 0..63 write data_a=random with we_a for one edge, drop we_a, hold addr_a -> q_a equals the written byte 1ns after the edge. Also set addr_b to the same address -> q_b shows the same value.
3. Port B write/read: repeat scenario 2 on port B, overwriting A's data, e.g. addr 5 <- 8'h3C -> q_b=8'h3C and q_a at addr 5 = 8'h3C.
4. Simultaneous distinct writes: A writes 8'h95 to addr 18 and B writes 8'h4B to addr 18+... e.g. addr 7, same edge -> q_a(addr 18)=8'h95 and q_b(addr 7)=8'h4B.
5. Same-address collision: A writes 8'hAA and B writes 8'h55 to addr 42 on the same edge -> both ports read 8'h55. With COLLISION_FLAG_EN, collision=1 for exactly one cycle, then 0.
6. Reset mid-operation: fill addr 10 with 8'hF0, then assert rst together with we_a=1/data_a=8'h11 at addr 10 -> after the edge q_a(addr 10)=8'h00. A write on the next non-reset edge stores normally.
